// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU codes, opcodes and the main-control bundle.
package cpu_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_W      = 3;
    localparam int unsigned OPC_W      = 7;

    typedef logic [ALU_W-1:0] alu_code_t;
    typedef logic [OPC_W-1:0] opcode_t;

    // ALU operation codes, shared with the ALU in EX
    localparam alu_code_t ALU_AND  = 3'b000;
    localparam alu_code_t ALU_XOR  = 3'b001;
    localparam alu_code_t ALU_SLL  = 3'b010;
    localparam alu_code_t ALU_ADD  = 3'b011;
    localparam alu_code_t ALU_SUB  = 3'b100;
    localparam alu_code_t ALU_MUL  = 3'b101;
    localparam alu_code_t ALU_ADDI = 3'b110;
    localparam alu_code_t ALU_SRAI = 3'b111;

    // Major opcodes
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;

    // Main-control bits carried down the pipe
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic alu_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [INSTR_W-1:0]    instr_i;
    logic                  valid_i;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic [XLEN-1:0]       imm_i;
    logic                  reg_write_i;
    logic                  mem_to_reg_i;
    logic                  mem_read_i;
    logic                  mem_write_i;
    logic                  alu_src_i;
    logic                  flush_i;

    logic                  stall_o;
    logic                  valid_o;
    logic                  reg_write_o;
    logic                  mem_to_reg_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic                  alu_src_o;
    alu_code_t             alu_ctrl_o;
    logic [XLEN-1:0]       rs1_data_o;
    logic [XLEN-1:0]       rs2_data_o;
    logic [XLEN-1:0]       imm_o;
    logic [REG_ADDR_W-1:0] rs1_addr_o;
    logic [REG_ADDR_W-1:0] rs2_addr_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [CNT_W-1:0]      bubble_cnt_o;

    modport master (
        output instr_i, valid_i, rs1_data_i, rs2_data_i, imm_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, flush_i,
        input  stall_o, valid_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o,
               alu_src_o, alu_ctrl_o, rs1_data_o, rs2_data_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o
    );

    modport slave (
        input  instr_i, valid_i, rs1_data_i, rs2_data_i, imm_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, flush_i,
        output stall_o, valid_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o,
               alu_src_o, alu_ctrl_o, rs1_data_o, rs2_data_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-code decode and rs2-usage detection for one instruction.
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output alu_code_t          alu_ctrl,
    output logic               uses_rs2
);

    localparam int unsigned FN_W = 10;

    // {funct7, funct3} selectors
    localparam logic [FN_W-1:0] FN_AND  = {7'b0000000, 3'b111};
    localparam logic [FN_W-1:0] FN_XOR  = {7'b0000000, 3'b100};
    localparam logic [FN_W-1:0] FN_SLL  = {7'b0000000, 3'b001};
    localparam logic [FN_W-1:0] FN_ADD  = {7'b0000000, 3'b000};
    localparam logic [FN_W-1:0] FN_SUB  = {7'b0100000, 3'b000};
    localparam logic [FN_W-1:0] FN_MUL  = {7'b0000001, 3'b000};
    localparam logic [FN_W-1:0] FN_SRAI = {7'b0100000, 3'b101};

    opcode_t         opcode;
    logic [FN_W-1:0] fn;
    logic            unused_fields;

    assign opcode        = instr[6:0];
    assign fn            = {instr[31:25], instr[14:12]};
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Opcode/funct decode; anything unrecognised falls back to add
    always_comb begin
        alu_ctrl = ALU_ADD;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs2 = 1'b1;
                case (fn)
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_MUL:  alu_ctrl = ALU_MUL;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            OPC_OP_IMM: begin
                if (fn[2:0] == 3'b000) begin
                    alu_ctrl = ALU_ADDI;
                end else if (fn == FN_SRAI) begin
                    alu_ctrl = ALU_SRAI;
                end
            end
            OPC_LOAD:   alu_ctrl = ALU_ADD;
            OPC_STORE: begin
                alu_ctrl = ALU_ADD;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                alu_ctrl = ALU_SUB;
                uses_rs2 = 1'b1;
            end
            default:    alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
)(
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    logic                  valid_q;
    ctrl_t                 ctrl_q;
    alu_code_t             alu_ctrl_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [CNT_W-1:0]      cnt_q;

    alu_code_t             alu_ctrl_c;
    logic                  uses_rs2_c;
    logic [REG_ADDR_W-1:0] rs1_c;
    logic [REG_ADDR_W-1:0] rs2_c;
    logic [REG_ADDR_W-1:0] rd_c;
    ctrl_t                 ctrl_in_c;
    logic                  hz_c;
    logic                  stall_c;
    logic                  bubble_c;

    alu_ctrl_dec u_dec (
        .instr    (bus.instr_i),
        .alu_ctrl (alu_ctrl_c),
        .uses_rs2 (uses_rs2_c)
    );

    assign rs1_c = bus.instr_i[19:15];
    assign rs2_c = bus.instr_i[24:20];
    assign rd_c  = bus.instr_i[11:7];

    assign ctrl_in_c = '{reg_write:  bus.reg_write_i,
                         mem_to_reg: bus.mem_to_reg_i,
                         mem_read:   bus.mem_read_i,
                         mem_write:  bus.mem_write_i,
                         alu_src:    bus.alu_src_i};

    // Load in EX whose destination is read by the instruction in ID
    assign hz_c = valid_q & ctrl_q.mem_read & (rd_addr_q != '0) & bus.valid_i &
                  ((rd_addr_q == rs1_c) | (uses_rs2_c & (rd_addr_q == rs2_c)));

    // A flush already squashes the dependent instruction, so no stall is needed
    assign stall_c  = hz_c & ~bus.flush_i;
    assign bubble_c = bus.flush_i | stall_c;

    // Pipeline register: reset, bubble (flush/stall/empty), or load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            alu_ctrl_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
        end else if (bubble_c || !bus.valid_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            alu_ctrl_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            valid_q    <= 1'b1;
            ctrl_q     <= ctrl_in_c;
            alu_ctrl_q <= alu_ctrl_c;
            rs1_data_q <= bus.rs1_data_i;
            rs2_data_q <= bus.rs2_data_i;
            imm_q      <= bus.imm_i;
            rs1_addr_q <= rs1_c;
            rs2_addr_q <= rs2_c;
            rd_addr_q  <= rd_c;
        end
    end

    // Saturating count of bubbles from flushes and stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (bubble_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_o      = stall_c;
    assign bus.valid_o      = valid_q;
    assign bus.reg_write_o  = ctrl_q.reg_write;
    assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
    assign bus.mem_read_o   = ctrl_q.mem_read;
    assign bus.mem_write_o  = ctrl_q.mem_write;
    assign bus.alu_src_o    = ctrl_q.alu_src;
    assign bus.alu_ctrl_o   = alu_ctrl_q;
    assign bus.rs1_data_o   = rs1_data_q;
    assign bus.rs2_data_o   = rs2_data_q;
    assign bus.imm_o        = imm_q;
    assign bus.rs1_addr_o   = rs1_addr_q;
    assign bus.rs2_addr_o   = rs2_addr_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage CPU, sitting directly upstream of the ALU. Each cycle it latches the decoded instruction's operands, immediate, register addresses and control bits. It also decodes the 3-bit ALU control code and detects load-use hazards, inserting a bubble into EX and asserting `stall_o` to freeze PC and IF/ID. A saturating counter reports how many bubbles have been inserted.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 32, bubble counter width
- `clk_i`  in  1  clock; all state on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `instr_i`  in  32  instruction currently in IF/ID
- `valid_i`  in  1  IF/ID holds a real instruction
- `rs1_data_i`, `rs2_data_i`, `imm_i`  in  XLEN  register-file read data, sign-extended immediate
- `reg_write_i`, `mem_to_reg_i`, `mem_read_i`, `mem_write_i`, `alu_src_i`  in  1 each  main-control outputs for the ID instruction
- `flush_i`  in  1  squash the ID instruction (taken branch)
- `stall_o`  out  1  combinational; hold PC and IF/ID this cycle
- `valid_o`  out  1  EX holds a real instruction
- `reg_write_o`, `mem_to_reg_o`, `mem_read_o`, `mem_write_o`, `alu_src_o`  out  1 each  registered control
- `alu_ctrl_o`  out  3  registered ALU code
- `rs1_data_o`, `rs2_data_o`, `imm_o`  out  XLEN  registered operands
- `rs1_addr_o`, `rs2_addr_o`, `rd_addr_o`  out  5  registered `instr[19:15]`, `[24:20]`, `[11:7]`
- `bubble_cnt_o`  out  CNT_W  bubbles inserted since reset

## Operation
- ALU code (combinational decode of `instr_i`, registered):
  - R-type `0110011`, selected by funct7/funct3:
    - and `0000000/111` → 000
    - xor `0000000/100` → 001
    - sll `0000000/001` → 010
    - add `0000000/000` → 011
    - sub `0100000/000` → 100
    - mul `0000001/000` → 101
  - I-type `0010011`: addi (f3 000) → 110; srai (f3 101, f7 `0100000`) → 111.
  - lw `0000011` and sw `0100011` → 011; beq `1100011` → 100.
  - Any other encoding → 011, with no error flag.
- Source usage:
  - rs1 is used by every valid instruction.
  - rs2 is used only by opcodes `0110011`, `0100011` and `1100011`.
- Hazard: `hz = valid_o & mem_read_o & (rd_addr_o != 0) & valid_i & ((rd_addr_o == rs1) | (uses_rs2 & rd_addr_o == rs2))`.
  - A lw followed by a sw on the same register also stalls; there is no MEM-stage store forwarding.
- `stall_o = hz & ~flush_i`.
- Per-edge update, highest priority first:
  - `rst_i`: all outputs 0, counter 0.
  - `flush_i` or `stall_o`: insert a bubble.
    - Bubble: `valid_o`, all five control bits, `alu_ctrl_o` and `rd_addr_o` go to 0; data fields and `rs1/rs2_addr_o` hold.
    - Counter increments by 1 unless it is all-ones.
  - `~valid_i`: same as bubble, but the counter does not increment.
  - Otherwise: load all fields from inputs and decode, and set `valid_o = 1`.

## Timing
- Latency 1 cycle from ID inputs to EX outputs.
- `stall_o` is combinational in the same cycle; it depends only on registered state plus `instr_i`, `valid_i` and `flush_i`.
- Load-use hazard:
  - Costs exactly one bubble.
  - After the bubble, `mem_read_o = 0`, so `stall_o` deasserts in the next cycle without a stall loop.
  - The held instruction then enters EX.
- `flush_i` and hazard in the same cycle: one bubble, `stall_o = 0`, counter +1.
- Reset mid-stall: the next cycle has `valid_o = 0` and `stall_o = 0`.
- The counter saturates; it does not wrap.

## Structure
- Package `cpu_pkg` holds:
  - the ALU code constants (`ALU_AND` … `ALU_SRAI`), shared with the ALU;
  - the opcode constants;
  - a `ctrl_t` struct bundling the five control bits.
- One sub-module, `alu_ctrl_dec`: purely combinational, `instr[31:0]` → `alu_ctrl[2:0]` plus `uses_rs2`.
- The top level holds the register and the counter.

## Test plan
- `add x3,x1,x2` (`0x002081B3`) with `rs1_data = 5`, `rs2_data = 7`, `valid_i = 1` → next cycle: `alu_ctrl_o = 011`, `rd_addr_o = 3`, `rs1_data_o = 5`, `valid_o = 1`, `stall_o = 0`.
- `lw x5,0(x1)`, then `sub x6,x5,x2` → one cycle `stall_o = 1` → bubble (`valid_o = 0`, `reg_write_o = 0`, `bubble_cnt_o = 1`) → sub enters EX with `alu_ctrl_o = 100`.
- `lw x0,0(x1)`, then `add x3,x0,x0` → `stall_o` never asserts.
- lw, then a dependent sw with `flush_i = 1` in the same cycle → `stall_o = 0`, bubble, counter +1.
- Decode sweep over and/xor/sll/mul/addi/srai/beq and an illegal opcode `0x0000007F` → codes 000/001/010/101/110/111/100/011.
- Counter preset to all-ones via repeated stalls (CNT_W=4 build): a 16th bubble leaves `bubble_cnt_o = 15`; `rst_i` pulsed mid-stall → all outputs 0 on the next edge.
